// File: rtl/event_encoder83.sv
// 8-line to 3-bit event encoder: captures request pulses into a pending register and
// drains them lowest-index-first over valid/ready. Optional EVENT_ENC_OVERFLOW_EN adds ovf_flag.
module event_encoder83 #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned CODE_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [N_IN-1:0]   req,
  input  logic              out_ready,
`ifdef EVENT_ENC_OVERFLOW_EN
  input  logic              ovf_clr,
  output logic              ovf_flag,
`endif
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [3:0]        pending_cnt,
  output logic              busy
);

  localparam logic StIdle = 1'b0;
  localparam logic StHold = 1'b1;

  logic              state_q, state_d;
  logic [N_IN-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [N_IN-1:0]   req_eff;
  logic [N_IN-1:0]   sel_mask;
  logic [N_IN-1:0]   clr_mask;
  logic [CODE_W-1:0] sel_code;
  logic              have_pend;

  always_comb begin
    req_eff   = en ? req : '0;
    have_pend = |pending_q;
    // Isolate the lowest set bit of the registered pending vector.
    sel_mask  = pending_q & (~pending_q + N_IN'(1));
    sel_code  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_mask[i]) sel_code = sel_code | CODE_W'(i);
    end

    state_d  = state_q;
    code_d   = code_q;
    clr_mask = '0;
    if (state_q == StIdle) begin
      if (have_pend) begin
        code_d   = sel_code;
        clr_mask = sel_mask;
        state_d  = StHold;
      end
    end else if (out_ready) begin
      if (have_pend) begin
        code_d   = sel_code;
        clr_mask = sel_mask;
      end else begin
        state_d = StIdle;
      end
    end

    // Set beats clear: a request on the line being loaded re-arms it.
    pending_d = (pending_q & ~clr_mask) | req_eff;

    cnt_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d = cnt_d + 4'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      code_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef EVENT_ENC_OVERFLOW_EN
  logic ovf_q;
  logic merge;

  // A merge is a request landing on a line that stays pending through this edge.
  assign merge = |(req_eff & pending_q & ~clr_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (merge) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_flag = ovf_q;
`endif

  assign out_valid   = (state_q == StHold);
  assign out_code    = code_q;
  assign pending_cnt = cnt_q;
  assign busy        = have_pend | out_valid;

endmodule

// File: tb/tb_event_encoder83.sv
// Self-checking bench for event_encoder83: vector table plus hand sequences, with a
// scoreboard queue of expected codes popped on each accepted handshake.
module tb_event_encoder83;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic [3:0] pending_cnt;
  logic       busy;
`ifdef EVENT_ENC_OVERFLOW_EN
  logic       ovf_clr;
  logic       ovf_flag;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] req;
    logic       en;
    int         cnt;
  } vec_t;

  vec_t vecs[7];

  event_encoder83 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .req         (req),
    .out_ready   (out_ready),
`ifdef EVENT_ENC_OVERFLOW_EN
    .ovf_clr     (ovf_clr),
    .ovf_flag    (ovf_flag),
`endif
    .out_valid   (out_valid),
    .out_code    (out_code),
    .pending_cnt (pending_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_codes(input logic [7:0] r);
    for (int b = 0; b < 8; b++) begin
      if (r[b]) exp_q.push_back(b);
    end
  endtask

  // An accept happens on the next rising edge whenever valid & ready hold at the falling edge.
  always @(negedge clk) begin
    if (mon_en && reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_code actual=%0d required=none", out_code);
      end else begin
        check("sb_code", 32'(out_code), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{req: 8'h20, en: 1'b1, cnt: 1};
    vecs[1] = '{req: 8'hA5, en: 1'b1, cnt: 4};
    vecs[2] = '{req: 8'h80, en: 1'b1, cnt: 1};
    vecs[3] = '{req: 8'hFF, en: 1'b1, cnt: 8};
    vecs[4] = '{req: 8'hFF, en: 1'b0, cnt: 0};
    vecs[5] = '{req: 8'h01, en: 1'b1, cnt: 1};
    vecs[6] = '{req: 8'h3C, en: 1'b1, cnt: 4};

    reset_n   = 1'b1;
    en        = 1'b1;
    req       = 8'h00;
    out_ready = 1'b1;
`ifdef EVENT_ENC_OVERFLOW_EN
    ovf_clr   = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_code", 32'(out_code), 0);
    check("rst_cnt", 32'(pending_cnt), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef EVENT_ENC_OVERFLOW_EN
    check("rst_ovf", 32'(ovf_flag), 0);
`endif
    #19 reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single-shot table: latency, capture count, drain order via scoreboard.
    foreach (vecs[i]) begin
      req = vecs[i].req;
      en  = vecs[i].en;
      out_ready = 1'b1;
      if (vecs[i].en) push_codes(vecs[i].req);
      tick();
      req = 8'h00;
      en  = 1'b1;
      check("cap_cnt", 32'(pending_cnt), 32'(vecs[i].cnt));
      check("lat_valid0", 32'(out_valid), 0);
      tick();
      check("lat_valid1", 32'(out_valid), 32'(vecs[i].cnt != 0));
      for (int t = 0; t < 20 && busy; t++) tick();
      check("drain_idle", 32'(busy), 0);
      check("sb_empty", 32'(exp_q.size()), 0);
    end

    // Priority drain count sequence 4,3,2,1,0 on consecutive edges.
    req = 8'hA5;
    push_codes(8'hA5);
    tick();
    req = 8'h00;
    for (int k = 0; k < 5; k++) begin
      check("drain_cnt", 32'(pending_cnt), 32'(4 - k));
      if (k > 0) check("drain_b2b", 32'(out_valid), 1);
      tick();
    end
    check("drain_end", 32'(out_valid), 0);

    // Backpressure: code 0 held stable for 5 cycles.
    out_ready = 1'b0;
    req = 8'h03;
    tick();
    req = 8'h00;
    tick();
    push_codes(8'h03);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_code", 32'(out_code), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_idle", 32'(busy), 0);
    check("bp_sb", 32'(exp_q.size()), 0);

    // Set beats clear: req[2] arrives on the edge that loads code 2.
    req = 8'h04;
    tick();
    push_codes(8'h04);
    push_codes(8'h04);
    tick();
    req = 8'h00;
    check("sbc_code", 32'(out_code), 2);
    check("sbc_cnt", 32'(pending_cnt), 1);
    tick();
    tick();
    check("sbc_idle", 32'(busy), 0);
    check("sbc_sb", 32'(exp_q.size()), 0);
`ifdef EVENT_ENC_OVERFLOW_EN
    check("sbc_ovf", 32'(ovf_flag), 0);
`endif

    // Merge: req[1] pulsed twice while pending, behind a stalled code 0.
    out_ready = 1'b0;
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    req = 8'h02;
    tick();
    tick();
    req = 8'h00;
    check("merge_cnt", 32'(pending_cnt), 1);
`ifdef EVENT_ENC_OVERFLOW_EN
    check("merge_ovf", 32'(ovf_flag), 1);
`endif
    push_codes(8'h01);
    push_codes(8'h02);
    out_ready = 1'b1;
    tick();
    tick();
    check("merge_idle", 32'(busy), 0);
    check("merge_sb", 32'(exp_q.size()), 0);
`ifdef EVENT_ENC_OVERFLOW_EN
    check("ovf_sticky", 32'(ovf_flag), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_flag), 0);
`endif

    // Async reset mid-HOLD with pending 0F.
    out_ready = 1'b0;
    req = 8'h0F;
    tick();
    req = 8'h01;
    tick();
    req = 8'h00;
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_cnt", 32'(pending_cnt), 4);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_code", 32'(out_code), 0);
    check("arst_cnt", 32'(pending_cnt), 0);
    check("arst_busy", 32'(busy), 0);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_sb", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
